pmt_pulse_conditioner: RTL

//   Front-end stage that feeds the photon up/down counter.

---
 rtl/pmt_pulse_conditioner.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pmt_pulse_conditioner.sv
// PMT front end: synchronises two async discriminator inputs, applies per-channel dead-time
// and resolves coincidences into single-cycle up/down/coinc strobes. Optional PMT_DROP_CNT_EN adds drop_cnt.
module pmt_pulse_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEADTIME    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pmt_up_in,
    input  logic       pmt_down_in,
    input  logic       count_en,
    output logic       up,
    output logic       down,
`ifdef PMT_DROP_CNT_EN
    output logic [7:0] drop_cnt,
`endif
    output logic       coinc
);

    localparam int CNT_W = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
    localparam bit HOLD_EN = (DEADTIME > 0);
    localparam logic [CNT_W-1:0] HOLD_INIT = HOLD_EN ? CNT_W'(DEADTIME - 1) : '0;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    // Channel index 0 = up, 1 = down throughout.
    logic [1:0]             pmt_in;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [1:0]             prev_q;
    logic [1:0]             edge_det;
    state_t                 state_q [2];
    state_t                 state_d [2];
    logic [CNT_W-1:0]       cnt_q [2];
    logic [CNT_W-1:0]       cnt_d [2];
    logic [1:0]             accept;
    logic [1:0]             drop;
    logic                   up_q, down_q, coinc_q;

    assign pmt_in = {pmt_down_in, pmt_up_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                sync_q[ch]  <= '0;
                state_q[ch] <= IDLE;
                cnt_q[ch]   <= '0;
            end
            prev_q <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                sync_q[ch]  <= {sync_q[ch][SYNC_STAGES-2:0], pmt_in[ch]};
                prev_q[ch]  <= sync_q[ch][SYNC_STAGES-1];
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            edge_det[ch] = sync_q[ch][SYNC_STAGES-1] & ~prev_q[ch];
        end
    end

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            case (state_q[ch])
                IDLE: begin
                    if (edge_det[ch] && count_en && HOLD_EN) begin
                        state_d[ch] = HOLD;
                        cnt_d[ch]   = HOLD_INIT;
                    end
                end
                HOLD: begin
                    if (cnt_q[ch] == '0) begin
                        state_d[ch] = IDLE;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
                    end
                end
                default: state_d[ch] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            accept[ch] = (state_q[ch] == IDLE) && edge_det[ch] && count_en;
            drop[ch]   = (state_q[ch] == HOLD) && edge_det[ch];
        end
    end

    // Strobes are registered one cycle after acceptance; simultaneous acceptance becomes coinc only.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            coinc_q <= 1'b0;
        end else begin
            up_q    <= accept[0] & ~accept[1];
            down_q  <= accept[1] & ~accept[0];
            coinc_q <= accept[0] & accept[1];
        end
    end

    assign up    = up_q;
    assign down  = down_q;
    assign coinc = coinc_q;

`ifdef PMT_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [8:0] drop_sum;

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + {8'd0, drop[0]} + {8'd0, drop[1]};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = ^drop;
`endif

endmodule
